// File: rtl/role_pkg.sv
// Shared types and defaults for the role-side AXI4-Stream ingress path.
package role_pkg;

    localparam int unsigned ROLE_DATA_W = 64;
    localparam int unsigned ROLE_KEEP_W = ROLE_DATA_W / 8;
    localparam int unsigned ROLE_DEPTH  = 16;

    typedef struct packed {
        logic [ROLE_DATA_W-1:0] tdata;
        logic [ROLE_KEEP_W-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

    typedef enum logic {
        GATE_IDLE,
        GATE_FWD
    } gate_state_e;

endpackage

// File: rtl/role_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, registered read, no array reset.
module role_fifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 73
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/role_axis_ingress.sv
// AXI4-Stream ingress FIFO with registered FWFT output and optional
// store-and-forward packet gate in front of the role core.
module role_axis_ingress
    import role_pkg::*;
#(
    parameter int unsigned DATA_W       = ROLE_DATA_W,
    parameter int unsigned DEPTH        = ROLE_DEPTH,
    parameter int unsigned AFULL_THRESH = 12,
    parameter int unsigned PKT_MODE     = 0
) (
    input  logic                       role_clk,
    input  logic                       role_rst,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic [DATA_W/8-1:0]        s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [DATA_W/8-1:0]        m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       almost_full,
    output logic                       pkt_oversize
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KW-1:0]     tkeep;
        logic              tlast;
    } beat_t;

    localparam int unsigned BW = $bits(beat_t);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d, pkt_count_q, pkt_count_d;
    logic          out_valid_q, out_valid_d, sel_byp_q, sel_byp_d;
    logic          oversize_q, oversize_d;
    beat_t         byp_q, byp_d;
    gate_state_e   gate_q, gate_d;

    logic          s_ready, m_valid, wr, rd, advance, ram_empty, ram_wr, ram_rd;
    logic [CW-1:0] ram_count;
    logic [BW-1:0] ram_rd_data;
    beat_t         s_beat, out_beat;

    assign s_beat   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign out_beat = sel_byp_q ? byp_q : beat_t'(ram_rd_data);

    // The output stage is either the bypass register (beat went straight in
    // while the RAM was empty) or the RAM read register; the mux select is a flop.
    always_comb begin
        s_ready   = !role_rst && (32'(fifo_count_q) < DEPTH);
        m_valid   = out_valid_q && (gate_q == GATE_FWD);
        wr        = s_axis_tvalid && s_ready;
        rd        = m_valid && m_axis_tready;
        ram_count = fifo_count_q - CW'(out_valid_q);
        ram_empty = (ram_count == '0);
        advance   = !out_valid_q || rd;
        ram_rd    = advance && !ram_empty;
        ram_wr    = wr && !(advance && ram_empty);

        out_valid_d = out_valid_q;
        sel_byp_d   = sel_byp_q;
        byp_d       = byp_q;
        if (advance) begin
            out_valid_d = !ram_empty || wr;
            if (!ram_empty) begin
                sel_byp_d = 1'b0;
            end else if (wr) begin
                sel_byp_d = 1'b1;
                byp_d     = s_beat;
            end
        end

        wr_ptr_d     = wr_ptr_q + AW'(ram_wr);
        rd_ptr_d     = rd_ptr_q + AW'(ram_rd);
        fifo_count_d = fifo_count_q + CW'(wr) - CW'(rd);
        pkt_count_d  = pkt_count_q + CW'(wr && s_axis_tlast) - CW'(rd && out_beat.tlast);
    end

    // Gate decisions look at next-cycle counts so a completed packet is
    // visible to the role the cycle after its tlast beat is written.
    always_comb begin
        gate_d     = gate_q;
        oversize_d = oversize_q;
        if (PKT_MODE == 0) begin
            gate_d = GATE_FWD;
        end else begin
            case (gate_q)
                GATE_IDLE: begin
                    if (pkt_count_d != '0) begin
                        gate_d = GATE_FWD;
                    end else if (32'(fifo_count_d) == DEPTH) begin
                        gate_d     = GATE_FWD;
                        oversize_d = 1'b1;
                    end
                end
                GATE_FWD: begin
                    if (rd && out_beat.tlast) begin
                        gate_d = GATE_IDLE;
                    end
                end
                default: gate_d = GATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge role_clk) begin
        if (role_rst) begin
            gate_q <= (PKT_MODE == 0) ? GATE_FWD : GATE_IDLE;
        end else begin
            gate_q <= gate_d;
        end
    end

    always_ff @(posedge role_clk) begin
        if (role_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            pkt_count_q  <= '0;
            out_valid_q  <= 1'b0;
            sel_byp_q    <= 1'b1;
            byp_q        <= '0;
            oversize_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            pkt_count_q  <= pkt_count_d;
            out_valid_q  <= out_valid_d;
            sel_byp_q    <= sel_byp_d;
            byp_q        <= byp_d;
            oversize_q   <= oversize_d;
        end
    end

    role_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_ram (
        .clk     (role_clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (s_beat),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = out_beat.tdata;
    assign m_axis_tkeep  = out_beat.tkeep;
    assign m_axis_tlast  = out_beat.tlast;
    assign fifo_count    = fifo_count_q;
    assign pkt_count     = pkt_count_q;
    assign almost_full   = (32'(fifo_count_q) >= AFULL_THRESH);
    assign pkt_oversize  = oversize_q;

endmodule

// File: tb/tb_role_axis_ingress.sv
// Directed and random checks of role_axis_ingress in cut-through and store-and-forward modes.
module tb_role_axis_ingress;
    import role_pkg::*;

    logic        role_clk = 1'b0;
    logic        role_rst = 1'b1;
    logic [63:0] s_tdata  = '0;
    logic [7:0]  s_tkeep  = '1;
    logic        s_tlast  = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;

    logic        ct_sready, ct_mvalid, ct_tlast, ct_afull, ct_oversize;
    logic [63:0] ct_tdata;
    logic [7:0]  ct_tkeep;
    logic [4:0]  ct_fcount, ct_pcount;
    logic        sf_sready, sf_mvalid, sf_tlast, sf_afull, sf_oversize;
    logic [63:0] sf_tdata;
    logic [7:0]  sf_tkeep;
    logic [4:0]  sf_fcount, sf_pcount;

    int n_vec = 0;
    int n_err = 0;

    always #5 role_clk = ~role_clk;

    role_axis_ingress #(.DATA_W(64), .DEPTH(16), .AFULL_THRESH(12), .PKT_MODE(0)) u_ct (
        .role_clk(role_clk), .role_rst(role_rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(ct_sready),
        .m_axis_tdata(ct_tdata), .m_axis_tkeep(ct_tkeep), .m_axis_tlast(ct_tlast),
        .m_axis_tvalid(ct_mvalid), .m_axis_tready(m_tready),
        .fifo_count(ct_fcount), .pkt_count(ct_pcount),
        .almost_full(ct_afull), .pkt_oversize(ct_oversize)
    );

    role_axis_ingress #(.DATA_W(64), .DEPTH(16), .AFULL_THRESH(12), .PKT_MODE(1)) u_sf (
        .role_clk(role_clk), .role_rst(role_rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(sf_sready),
        .m_axis_tdata(sf_tdata), .m_axis_tkeep(sf_tkeep), .m_axis_tlast(sf_tlast),
        .m_axis_tvalid(sf_mvalid), .m_axis_tready(m_tready),
        .fifo_count(sf_fcount), .pkt_count(sf_pcount),
        .almost_full(sf_afull), .pkt_oversize(sf_oversize)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge role_clk);
        role_rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '1;
        m_tready = 1'b0;
        repeat (3) @(negedge role_clk);
        role_rst = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          tv;
        logic [63:0] data;
        bit          mr;
        bit          chk_st;
        bit          sr;
        bit          mv;
        int          cnt;
        bit          chk_d;
        logic [63:0] d;
        bit          chk_rst;
    } vec_t;

    vec_t tab[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        axis_beat_t q[$];
        axis_beat_t nb, prev;
        int pk, sent, in_idx, out_idx;
        bit prev_stall, released, pend;

        // ---- Test 1: reset with tvalid held high, then first beat latency
        //            rst tv data      mr chk sr mv cnt chk_d d       chk_rst
        tab[0] = '{1, 1, 64'hA5, 0, 0, 0, 0, 0, 0, 64'h0,  0};
        tab[1] = '{1, 1, 64'hA5, 0, 1, 0, 0, 0, 1, 64'h0,  1};
        tab[2] = '{1, 1, 64'hA5, 0, 1, 0, 0, 0, 1, 64'h0,  1};
        tab[3] = '{0, 1, 64'hA5, 0, 1, 1, 0, 0, 0, 64'h0,  0};
        tab[4] = '{0, 0, 64'h0,  0, 1, 1, 1, 1, 1, 64'hA5, 0};
        tab[5] = '{0, 0, 64'h0,  1, 1, 1, 1, 1, 1, 64'hA5, 0};
        tab[6] = '{0, 0, 64'h0,  1, 1, 1, 0, 0, 0, 64'h0,  0};

        for (int i = 0; i < 7; i++) begin
            @(negedge role_clk);
            role_rst = tab[i].rst;
            s_tvalid = tab[i].tv;
            s_tdata  = tab[i].data;
            s_tkeep  = '1;
            s_tlast  = 1'b0;
            m_tready = tab[i].mr;
            #1;
            chk($sformatf("t1_v%0d_sready", i), ct_sready, tab[i].sr);
            if (tab[i].chk_st) begin
                chk($sformatf("t1_v%0d_mvalid", i), ct_mvalid, tab[i].mv);
                chk($sformatf("t1_v%0d_fcount", i), ct_fcount, tab[i].cnt);
            end
            if (tab[i].chk_d) chk($sformatf("t1_v%0d_tdata", i), ct_tdata, tab[i].d);
            if (tab[i].chk_rst) begin
                chk("t1_rst_tkeep", ct_tkeep, 0);
                chk("t1_rst_tlast", ct_tlast, 0);
                chk("t1_rst_pcount", ct_pcount, 0);
                chk("t1_rst_afull", ct_afull, 0);
                chk("t1_rst_oversize", ct_oversize, 0);
                chk("t1_rst_sf_sready", sf_sready, 0);
                chk("t1_rst_sf_mvalid", sf_mvalid, 0);
                chk("t1_rst_sf_fcount", sf_fcount, 0);
                chk("t1_rst_sf_afull", sf_afull, 0);
                chk("t1_rst_sf_oversize", sf_oversize, 0);
                chk("t1_rst_sf_tdata", sf_tdata, 0);
            end
        end

        // ---- Test 2: fill with role stalled, then drain
        do_reset();
        for (int i = 0; i < 20; i++) begin
            int ec;
            @(negedge role_clk);
            s_tvalid = 1'b1;
            s_tdata  = 64'(i);
            m_tready = 1'b0;
            #1;
            ec = (i < 16) ? i : 16;
            chk($sformatf("t2_fill%0d_fcount", i), ct_fcount, ec);
            chk($sformatf("t2_fill%0d_sready", i), ct_sready, ec < 16);
            chk($sformatf("t2_fill%0d_afull", i), ct_afull, ec >= 12);
            chk($sformatf("t2_fill%0d_mvalid", i), ct_mvalid, i > 0);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge role_clk);
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            #1;
            chk($sformatf("t2_drain%0d_mvalid", k), ct_mvalid, 1);
            chk($sformatf("t2_drain%0d_tdata", k), ct_tdata, k);
            chk($sformatf("t2_drain%0d_fcount", k), ct_fcount, 16 - k);
            chk($sformatf("t2_drain%0d_sready", k), ct_sready, k > 0);
            chk($sformatf("t2_drain%0d_afull", k), ct_afull, (16 - k) >= 12);
        end
        @(negedge role_clk);
        #1;
        chk("t2_empty_mvalid", ct_mvalid, 0);
        chk("t2_empty_fcount", ct_fcount, 0);

        // ---- Test 3: 100 beats streaming at full rate
        do_reset();
        for (int c = 0; c <= 101; c++) begin
            @(negedge role_clk);
            m_tready = 1'b1;
            s_tvalid = (c < 100);
            s_tdata  = 64'h3000 + 64'(c);
            #1;
            if (c == 0) begin
                chk("t3_first_mvalid", ct_mvalid, 0);
            end else if (c <= 100) begin
                chk($sformatf("t3_c%0d_mvalid", c), ct_mvalid, 1);
                chk($sformatf("t3_c%0d_tdata", c), ct_tdata, 64'h3000 + 64'(c - 1));
                chk($sformatf("t3_c%0d_fcount", c), ct_fcount, 1);
                chk($sformatf("t3_c%0d_sready", c), ct_sready, 1);
            end else begin
                chk("t3_end_mvalid", ct_mvalid, 0);
                chk("t3_end_fcount", ct_fcount, 0);
            end
        end

        // ---- Test 4: store-and-forward, 5-beat packet with 2 idle cycles between beats
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            @(negedge role_clk);
            m_tready = 1'b1;
            s_tvalid = (c % 3 == 0) && (c < 15);
            s_tdata  = 64'h4000 + 64'(c / 3);
            s_tlast  = (c == 12);
            #1;
            if (c <= 12) begin
                chk($sformatf("t4_c%0d_mvalid", c), sf_mvalid, 0);
                chk($sformatf("t4_c%0d_pcount", c), sf_pcount, 0);
            end else if (c <= 17) begin
                chk($sformatf("t4_c%0d_mvalid", c), sf_mvalid, 1);
                chk($sformatf("t4_c%0d_tdata", c), sf_tdata, 64'h4000 + 64'(c - 13));
                chk($sformatf("t4_c%0d_tlast", c), sf_tlast, c == 17);
                chk($sformatf("t4_c%0d_pcount", c), sf_pcount, 1);
                if (c == 13) chk("t4_release_fcount", sf_fcount, 5);
            end else begin
                chk($sformatf("t4_c%0d_mvalid", c), sf_mvalid, 0);
                chk($sformatf("t4_c%0d_pcount", c), sf_pcount, 0);
            end
        end

        // ---- Test 5: store-and-forward, 20-beat packet overflows the buffer
        do_reset();
        in_idx = 0;
        out_idx = 0;
        released = 1'b0;
        for (int c = 0; c < 200 && out_idx < 20; c++) begin
            @(negedge role_clk);
            m_tready = 1'b1;
            s_tvalid = (in_idx < 20);
            s_tdata  = 64'h5000 + 64'(in_idx);
            s_tlast  = (in_idx == 19);
            #1;
            if (!released && sf_mvalid) begin
                released = 1'b1;
                chk("t5_release_fcount", sf_fcount, 16);
                chk("t5_release_oversize", sf_oversize, 1);
            end
            if (sf_mvalid) begin
                chk($sformatf("t5_beat%0d_tdata", out_idx), sf_tdata, 64'h5000 + 64'(out_idx));
                chk($sformatf("t5_beat%0d_tlast", out_idx), sf_tlast, out_idx == 19);
                chk($sformatf("t5_beat%0d_tkeep", out_idx), sf_tkeep, 8'hFF);
                out_idx++;
            end
            if (s_tvalid && sf_sready) in_idx++;
        end
        chk("t5_beats_delivered", out_idx, 20);
        @(negedge role_clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        chk("t5_after_mvalid", sf_mvalid, 0);
        chk("t5_after_oversize", sf_oversize, 1);
        chk("t5_after_afull", sf_afull, 0);

        // ---- Test 6: random traffic against a scoreboard, 50% role backpressure
        do_reset();
        pk = 0;
        sent = 0;
        pend = 1'b0;
        prev_stall = 1'b0;
        prev = '0;
        for (int c = 0; c < 20000 && (sent < 1000 || q.size() > 0); c++) begin
            @(negedge role_clk);
            if (!pend) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = {$urandom, $urandom};
                    s_tkeep  = 8'($urandom_range(0, 255));
                    s_tlast  = ($urandom_range(0, 3) == 0);
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            m_tready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk("t6_stall_mvalid", ct_mvalid, 1);
                chk("t6_stall_tdata", ct_tdata, prev.tdata);
                chk("t6_stall_tkeep", ct_tkeep, prev.tkeep);
                chk("t6_stall_tlast", ct_tlast, prev.tlast);
            end
            chk("t6_fcount", ct_fcount, q.size());
            chk("t6_pcount", ct_pcount, pk);
            chk("t6_afull", ct_afull, q.size() >= 12);
            if (ct_mvalid) begin
                if (q.size() == 0) begin
                    chk("t6_spurious_mvalid", ct_mvalid, 0);
                end else begin
                    chk("t6_tdata", ct_tdata, q[0].tdata);
                    chk("t6_tkeep", ct_tkeep, q[0].tkeep);
                    chk("t6_tlast", ct_tlast, q[0].tlast);
                    if (m_tready) begin
                        if (q[0].tlast) pk--;
                        void'(q.pop_front());
                    end
                end
            end
            prev_stall = ct_mvalid && !m_tready;
            prev.tdata = ct_tdata;
            prev.tkeep = ct_tkeep;
            prev.tlast = ct_tlast;
            if (s_tvalid && ct_sready) begin
                nb.tdata = s_tdata;
                nb.tkeep = s_tkeep;
                nb.tlast = s_tlast;
                q.push_back(nb);
                if (s_tlast) pk++;
                sent++;
                pend = 1'b0;
            end else begin
                pend = s_tvalid;
            end
        end
        chk("t6_sent", sent, 1000);
        chk("t6_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
